sti_pixel_fetch: RTL
====================

// Module: sti_pixel_fetch
// PURPOSE
// Upstream stage of the DT distance-transform core. Reads the packed 1-bit binary image from sti ROM
// (1024 x 16-bit words, 128x128 pixels, raster order) and unpacks it into a 1-pixel/cycle stream.
// The stream carries x/y coordinates and uses a valid/ready handshake.
// The DT core consumes the stream for its forward pass instead of addressing sti ROM directly.
// PARAMETERS
// IMG_W   128  image width in pixels; multiple of WORD_W
// IMG_H   128  image height in pixels
// WORD_W  16   sti word width, pixels per word
// ADDR_W  10   sti address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H/WORD_W
// PORTS
// clk        in   1       system clock; all logic on posedge
// reset      in   1       asynchronous, active-high reset
// start      in   1       1-cycle pulse: begin fetching a frame; honoured only in IDLE
// busy       out  1       high from the cycle after start until done is asserted
// done       out  1       1-cycle pulse after the last pixel is accepted
// sti_rd     out  1       ROM read enable
// sti_addr   out  ADDR_W  ROM word address
// sti_di     in   WORD_W  ROM data; valid at the posedge following the sti_rd/sti_addr cycle (ROM latches on negedge)
// pix_valid  out  1       pixel stream valid
// pix_ready  in   1       downstream ready; a transfer occurs when pix_valid & pix_ready
// pix_data   out  1       pixel value (1 = object, 0 = background)
// pix_x      out  7       column 0..IMG_W-1
// pix_y      out  7       row 0..IMG_H-1
// pix_last   out  1       high with the pixel at (IMG_W-1, IMG_H-1)
// BEHAVIOUR
// - Reset values: busy=0, done=0, sti_rd=0, sti_addr=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_last=0.
// - FSM IDLE -> RUN on start. RUN -> DRAIN after the read of the final word (addr 1023) is issued.
//   DRAIN -> DONE when the pixel with pix_last is accepted. DONE -> IDLE after 1 cycle; done=1 in DONE only.
// - Bit order: word at address a holds pixels a*16 .. a*16+15; sti_di[15] is the leftmost pixel,
//   sti_di[0] the rightmost.
// - Buffering is a 2-entry word FIFO.
//   - A read is issued in a cycle when (FIFO occupancy + reads in flight) < 2.
//   - sti_di is written into the FIFO at the next posedge.
//   - sti_addr increments by 1 per issued read. It never wraps; it holds 1023 after the last read.
// - Unpacker: a 4-bit bit index walks 15..0 over the head word; the word is popped when bit 0 is accepted.
// - Throughput: the first pixel_valid appears 2 cycles after start.
//   - With pix_ready held high, there are no bubbles: 16384 pixels in 16384 consecutive cycles.
// - Stall: while pix_valid=1 and pix_ready=0, pix_data/pix_x/pix_y/pix_last are held stable.
//   pix_valid does not drop once raised until a transfer occurs.
// - Coordinates: pix_x increments per transfer and wraps 127 -> 0 with a pix_y increment.
// - start while busy or in DONE is ignored. A start and a final acceptance in the same cycle: start is ignored.
// - Reset asserted mid-frame: the frame is aborted immediately and all outputs take their reset values.
//   The FIFO and in-flight reads are discarded. The next start refetches from addr 0.
// - A pix_ready toggle has no effect while pix_valid=0.
// CONFIGURATION
// - BORDER_ZERO_EN defined: pix_data is forced to 0 when pix_x in {0,127} or pix_y in {0,127},
//   regardless of ROM content. Use this when the DT core requires a background border.
// - BORDER_ZERO_EN undefined: pix_data is the raw ROM bit everywhere.
// - Timing, handshake and coordinates are identical in both builds.
// TESTING
// 1. ROM all 0xFFFF, pix_ready=1, start -> 16384 transfers in consecutive cycles; pix_last only at (127,127);
//    done pulses once, busy falls with it.
// 2. ROM addr0=0x8001, addr8=0x4000, rest 0 -> ones only at (0,0), (15,0) and (1,1); every other pixel is 0.
// 3. Random pixel ROM, pix_ready random at 30% high -> accepted stream is bit-identical to scenario with
//    ready=1; no pixel is dropped or duplicated; outputs stay stable during stalls.
// 4. Reset pulsed after 5000 transfers -> outputs return to reset values that cycle; a new start yields
//    the first pixel from addr 0 at (0,0).
// 5. start pulsed again mid-frame -> ignored; transfer count stays 16384 with exactly one done.
// 6. BORDER_ZERO_EN defined, ROM all 0xFFFF -> border pixels (508 of them) are 0;
//    the interior 126x126 = 15876 pixels are 1.

Source files
------------

// File: rtl/sti_pixel_fetch.sv
// Unpacks the packed 1-bit sti ROM image into a 1-pixel/cycle valid/ready stream with x/y coordinates.
// Optional build macro BORDER_ZERO_EN forces the outermost image ring to background (0).
module sti_pixel_fetch #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       sti_rd,
  output logic [ADDR_W-1:0]          sti_addr,
  input  logic [WORD_W-1:0]          sti_di,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_data,
  output logic [$clog2(IMG_W)-1:0]   pix_x,
  output logic [$clog2(IMG_H)-1:0]   pix_y,
  output logic                       pix_last
);

  localparam int NUM_WORDS = IMG_W * IMG_H / WORD_W;
  localparam int BIT_W     = $clog2(WORD_W);
  localparam int X_W       = $clog2(IMG_W);
  localparam int Y_W       = $clog2(IMG_H);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(WORD_W - 1);
  localparam logic [X_W-1:0]    X_MAX     = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   fifo_mem_q [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;

  logic issue;
  logic push;
  logic pop;
  logic xfer;
  logic at_last;
  logic frame_start;
  logic raw_bit;

  // A read returns its word at the very next edge, so no read is ever still
  // in flight at the start of a cycle: occupancy alone bounds the issue.
  assign issue       = (state_q == S_RUN) && (fifo_cnt_q < 2'd2);
  assign push        = issue;
  assign pix_valid   = (fifo_cnt_q != 2'd0);
  assign xfer        = pix_valid && pix_ready;
  assign pop         = xfer && (bit_q == '0);
  assign at_last     = (x_q == X_MAX) && (y_q == Y_MAX);
  assign frame_start = (state_q == S_IDLE) && start;
  assign raw_bit     = fifo_mem_q[rd_ptr_q][bit_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
      S_DRAIN: if (xfer && at_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    fifo_cnt_d = fifo_cnt_q;
    bit_d      = bit_q;
    x_d        = x_q;
    y_d        = y_q;

    if (frame_start) begin
      addr_d = '0;
    end else if (issue && (addr_q != LAST_ADDR)) begin
      addr_d = addr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // Bit index runs MSB-first and wraps to TOP_BIT as the word is popped.
    if (frame_start) begin
      bit_d = TOP_BIT;
      x_d   = '0;
      y_d   = '0;
    end else if (xfer) begin
      bit_d = bit_q - 1'b1;
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      bit_q      <= TOP_BIT;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      bit_q      <= bit_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  // NOTE: FIFO storage has no reset; an empty count hides stale words and pix_data is gated by pix_valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= sti_di;
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign sti_rd   = issue;
  assign sti_addr = addr_q;
  assign pix_x    = x_q;
  assign pix_y    = y_q;
  assign pix_last = pix_valid && at_last;

`ifdef BORDER_ZERO_EN
  logic on_border;
  assign on_border = (x_q == '0) || (x_q == X_MAX) || (y_q == '0) || (y_q == Y_MAX);
  assign pix_data  = pix_valid && raw_bit && !on_border;
`else
  assign pix_data  = pix_valid && raw_bit;
`endif

endmodule
